mash_ncl: RTL and testbench
===========================

MASH_NCL -- requirements
Module: mash_ncl

Interface
REQ-001 SHALL have parameter P_INT_WIDTH, default 8, which sets the width of the integer divide value.
REQ-002 SHALL have port i_clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-003 SHALL have port i_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port i_en, input, 1 bit: pipeline advance enable.
REQ-005 SHALL have port i_clr, input, 1 bit: synchronous clear of history and fill state.
REQ-006 SHALL have port i_order, input, 2 bits: MASH order, 0 = bypass, 1 to 3 = active stages.
REQ-007 SHALL have ports i_q1, i_q2, i_q3, input, 1 bit each: quantize/carry bits from MASH stages 1, 2 and 3.
REQ-008 SHALL have port i_int, input, P_INT_WIDTH bits: unsigned integer divide value.
REQ-009 SHALL have port o_ncl, output, 4 bits: signed two's-complement noise-cancel value, range -3..+4.
REQ-010 SHALL have port o_div, output, P_INT_WIDTH+1 bits: unsigned divide value, i_int + o_ncl, saturated.
REQ-011 SHALL have port o_valid, output, 1 bit: o_ncl and o_div are valid.
REQ-012 SHALL have port o_sat, output, 1 bit: o_div was clamped in this output.

Function
REQ-013 Define an "enabled edge" as a rising edge with i_en=1 and i_clr=0; the history registers SHALL update only on enabled edges.
REQ-014 History per enabled edge SHALL be:
- q1d1 <= i_q1, q1d2 <= q1d1
- q2d1 <= i_q2, q2d2 <= q2d1
- q3d1 <= i_q3, q3d2 <= q3d1
REQ-015 Aligned terms SHALL be: a1 = q1d2; a2 = q2d1; a2p = q2d2; a3 = i_q3; a3p = q3d1; a3pp = q3d2.
REQ-016 On each enabled edge, o_ncl SHALL register the following, by order:
- i_order=0: 0
- i_order=1: a1
- i_order=2: a1 + (a2 - a2p)
- i_order=3: a1 + (a2 - a2p) + (a3 - 2*a3p + a3pp)
REQ-017 All o_ncl arithmetic SHALL be signed and at least 4 bits wide, with no overflow across -3..+4.
REQ-018 On the same enabled edge, o_div SHALL register s = zero-extended i_int + sign-extended o_ncl-next, evaluated at P_INT_WIDTH+2 bits.
REQ-019 If s < 0, o_div SHALL register 0 and o_sat SHALL register 1; otherwise o_div SHALL register s[P_INT_WIDTH:0] and o_sat SHALL register 0.
REQ-020 The upper bound cannot overflow: 2^P_INT_WIDTH - 1 + 4 fits in P_INT_WIDTH+1 bits.
REQ-021 Fill FSM states SHALL be IDLE, FILL and RUN, with a 2-bit fill counter cnt.
REQ-022 IDLE to FILL SHALL occur on an enabled edge, with cnt set to 1.
REQ-023 In FILL, cnt SHALL increment on each enabled edge; on the enabled edge where cnt==2, the FSM SHALL go to RUN.
REQ-024 o_valid SHALL register 1 on an enabled edge that ends in RUN or occurs in RUN; o_valid SHALL therefore first rise on the 3rd enabled edge after IDLE.
REQ-025 On any edge with i_en=0, all registers except o_valid SHALL hold, o_valid SHALL register 0, and state and cnt SHALL hold (no refill).
REQ-026 i_clr=1 SHALL take priority over i_en:
- history registers, o_ncl, o_div, o_sat and o_valid cleared to 0
- cnt cleared to 0
- state set to IDLE
REQ-027 The block SHALL register i_order on each enabled edge.
REQ-028 If i_order differs from its registered copy on an enabled edge, the FSM SHALL go to FILL with cnt=1 and o_valid SHALL register 0.
REQ-029 The history registers SHALL still advance on that edge, and o_ncl SHALL be computed with the new i_order.
REQ-030 Simultaneous i_clr and an order change: i_clr wins, and the registered i_order SHALL load the new value.

Reset
REQ-031 While i_rst_n=0, regardless of clock, the block SHALL asynchronously force:
- all history registers to 0
- registered i_order to 0
- o_ncl=0, o_div=0, o_valid=0, o_sat=0
- state=IDLE, cnt=0
REQ-032 The first enabled edge after reset release SHALL start FILL.
REQ-033 Reset asserted mid-RUN SHALL discard all history, and o_valid SHALL stay 0 until 3 enabled edges after release.

Verification
REQ-034 Reset with random inputs toggling -> o_ncl=0, o_div=0, o_valid=0, o_sat=0 throughout reset.
REQ-035 i_order=1, i_int=20, i_q1=1 constant, i_en=1 -> o_valid rises after edge 3; thereafter o_ncl=+1, o_div=21, o_sat=0.
REQ-036 i_order=3, i_int=20, q1=q2=0, q3=1 at enabled edge k only (k>=3) -> o_ncl = +1, -2, +1 and o_div = 21, 18, 21 after edges k, k+1, k+2; o_div=20 otherwise.
REQ-037 i_order=3, i_int=1, q3 pattern 0,1,0 giving -2 -> o_div=0 with o_sat=1 for that output; next output o_div=2, o_sat=0.
REQ-038 In RUN, i_order changes 3->2 -> o_valid=0 for 2 enabled edges, returns to 1 on the 3rd; outputs follow the order-2 formula.
REQ-039 In RUN, i_en=0 for 4 cycles, then 1 -> registers hold, o_valid=0 during the gap, and o_valid=1 again after the first enabled edge (no refill).

Source files
------------

// File: rtl/mash_ncl.sv
// MASH noise-cancellation network: combines stage carry bits into a signed
// correction, adds it to the integer divide value and gates output validity.
module mash_ncl #(
    parameter int unsigned P_INT_WIDTH = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_en,
    input  logic                   i_clr,
    input  logic [1:0]             i_order,
    input  logic                   i_q1,
    input  logic                   i_q2,
    input  logic                   i_q3,
    input  logic [P_INT_WIDTH-1:0] i_int,
    output logic [3:0]             o_ncl,
    output logic [P_INT_WIDTH:0]   o_div,
    output logic                   o_valid,
    output logic                   o_sat
);

    localparam int unsigned SW = P_INT_WIDTH + 2;

    typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

    state_t                 state, state_nxt;
    logic [1:0]             cnt, cnt_nxt;
    logic                   valid_nxt;
    logic [1:0]             order_r;
    logic                   q1d1, q1d2, q2d1, q2d2, q3d1, q3d2;

    logic signed [3:0]      t1, t2, t3, ncl_nxt;
    logic signed [SW-1:0]   ncl_ext, sum;
    logic [P_INT_WIDTH:0]   div_nxt;
    logic                   sat_nxt;

    // Differentiated, delay-aligned stage terms; the new order selects the mix
    always_comb begin
        t1 = $signed({3'b000, q1d2});
        t2 = $signed({3'b000, q2d1}) - $signed({3'b000, q2d2});
        t3 = $signed({3'b000, i_q3}) - $signed({2'b00, q3d1, 1'b0})
           + $signed({3'b000, q3d2});
        case (i_order)
            2'd0:    ncl_nxt = 4'sd0;
            2'd1:    ncl_nxt = t1;
            2'd2:    ncl_nxt = t1 + t2;
            default: ncl_nxt = t1 + t2 + t3;
        endcase
    end

    // Offset divide value; only the negative side can clamp
    always_comb begin
        ncl_ext = {{(SW-4){ncl_nxt[3]}}, ncl_nxt};
        sum     = $signed({2'b00, i_int}) + ncl_ext;
        sat_nxt = sum[SW-1];
        div_nxt = sat_nxt ? '0 : sum[P_INT_WIDTH:0];
    end

    // Fill tracking, evaluated as if this were an enabled edge
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        valid_nxt = 1'b0;
        if (i_order != order_r) begin
            state_nxt = FILL;
            cnt_nxt   = 2'd1;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = FILL;
                    cnt_nxt   = 2'd1;
                end
                FILL: begin
                    if (cnt == 2'd2) begin
                        state_nxt = RUN;
                        valid_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt + 2'd1;
                    end
                end
                RUN:     valid_nxt = 1'b1;
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = 2'd0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            cnt     <= 2'd0;
            order_r <= 2'd0;
            q1d1    <= 1'b0;
            q1d2    <= 1'b0;
            q2d1    <= 1'b0;
            q2d2    <= 1'b0;
            q3d1    <= 1'b0;
            q3d2    <= 1'b0;
            o_ncl   <= 4'd0;
            o_div   <= '0;
            o_valid <= 1'b0;
            o_sat   <= 1'b0;
        end else if (i_clr) begin
            // Clear wins over enable but still captures the order
            state   <= IDLE;
            cnt     <= 2'd0;
            order_r <= i_order;
            q1d1    <= 1'b0;
            q1d2    <= 1'b0;
            q2d1    <= 1'b0;
            q2d2    <= 1'b0;
            q3d1    <= 1'b0;
            q3d2    <= 1'b0;
            o_ncl   <= 4'd0;
            o_div   <= '0;
            o_valid <= 1'b0;
            o_sat   <= 1'b0;
        end else if (i_en) begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            order_r <= i_order;
            q1d1    <= i_q1;
            q1d2    <= q1d1;
            q2d1    <= i_q2;
            q2d2    <= q2d1;
            q3d1    <= i_q3;
            q3d2    <= q3d1;
            o_ncl   <= ncl_nxt;
            o_div   <= div_nxt;
            o_valid <= valid_nxt;
            o_sat   <= sat_nxt;
        end else begin
            o_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mash_ncl.sv
// Directed scoreboard bench for mash_ncl: each step queues its expected
// outputs, advances one clock and compares the popped entry against the DUT.
module tb_mash_ncl;

    localparam int unsigned W = 8;

    logic         i_clk;
    logic         i_rst_n;
    logic         i_en;
    logic         i_clr;
    logic [1:0]   i_order;
    logic         i_q1, i_q2, i_q3;
    logic [W-1:0] i_int;
    logic [3:0]   o_ncl;
    logic [W:0]   o_div;
    logic         o_valid;
    logic         o_sat;

    typedef struct {
        string      tag;
        logic       valid;
        logic [3:0] ncl;
        logic [W:0] div;
        logic       sat;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    mash_ncl #(.P_INT_WIDTH(W)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (i_en),
        .i_clr   (i_clr),
        .i_order (i_order),
        .i_q1    (i_q1),
        .i_q2    (i_q2),
        .i_q3    (i_q3),
        .i_int   (i_int),
        .o_ncl   (o_ncl),
        .o_div   (o_div),
        .o_valid (o_valid),
        .o_sat   (o_sat)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input exp_t e);
        check({e.tag, ".valid"}, 16'(o_valid), 16'(e.valid));
        check({e.tag, ".ncl"},   16'(o_ncl),   16'(e.ncl));
        check({e.tag, ".div"},   16'(o_div),   16'(e.div));
        check({e.tag, ".sat"},   16'(o_sat),   16'(e.sat));
    endtask

    // Drive one cycle of inputs, queue the expected result, clock, compare
    task automatic step(input string tag, input bit en, input bit clr, input int ord,
                        input bit q1, input bit q2, input bit q3, input int iv,
                        input bit ev, input int encl, input int ediv, input bit esat);
        exp_t e;
        i_en    = en;
        i_clr   = clr;
        i_order = 2'(ord);
        i_q1    = q1;
        i_q2    = q2;
        i_q3    = q3;
        i_int   = W'(iv);
        e.tag   = tag;
        e.valid = ev;
        e.ncl   = 4'(encl);
        e.div   = (W+1)'(ediv);
        e.sat   = esat;
        sb.push_back(e);
        @(posedge i_clk);
        #1;
        if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $error("FAIL %s: observed empty scoreboard expected one entry", tag);
        end else begin
            check_all(sb.pop_front());
        end
    endtask

    initial begin
        exp_t z;
        z.valid = 1'b0; z.ncl = 4'd0; z.div = '0; z.sat = 1'b0;

        i_rst_n = 1'b0; i_en = 1'b0; i_clr = 1'b0; i_order = 2'd0;
        i_q1 = 1'b0; i_q2 = 1'b0; i_q3 = 1'b0; i_int = '0;

        // Outputs stay zero while reset is held, whatever the inputs do
        for (int i = 0; i < 6; i++) begin
            i_en    = 1'($urandom);
            i_clr   = 1'($urandom);
            i_order = 2'($urandom);
            i_q1    = 1'($urandom);
            i_q2    = 1'($urandom);
            i_q3    = 1'($urandom);
            i_int   = W'($urandom);
            @(posedge i_clk);
            #1;
            z.tag = $sformatf("rst%0d", i);
            check_all(z);
        end
        i_en = 1'b0; i_clr = 1'b0;
        i_rst_n = 1'b1;

        // Order 1, constant q1: valid after third edge, then +1 / 21
        step("o1_e1", 1, 0, 1, 1, 0, 0, 20,   0,  0, 20, 0);
        step("o1_e2", 1, 0, 1, 1, 0, 0, 20,   0,  0, 20, 0);
        step("o1_e3", 1, 0, 1, 1, 0, 0, 20,   1,  1, 21, 0);
        step("o1_e4", 1, 0, 1, 1, 0, 0, 20,   1,  1, 21, 0);
        step("o1_e5", 1, 0, 1, 1, 0, 0, 20,   1,  1, 21, 0);

        // Clear alongside an order change: history gone, order 3 captured
        step("clr",   1, 1, 3, 0, 0, 0, 20,   0,  0,  0, 0);
        step("o3_f1", 1, 0, 3, 0, 0, 0, 20,   0,  0, 20, 0);
        step("o3_f2", 1, 0, 3, 0, 0, 0, 20,   0,  0, 20, 0);
        step("o3_f3", 1, 0, 3, 0, 0, 0, 20,   1,  0, 20, 0);

        // Single q3 pulse through the second-difference term
        step("q3_k0", 1, 0, 3, 0, 0, 1, 20,   1,  1, 21, 0);
        step("q3_k1", 1, 0, 3, 0, 0, 0, 20,   1, -2, 18, 0);
        step("q3_k2", 1, 0, 3, 0, 0, 0, 20,   1,  1, 21, 0);
        step("q3_k3", 1, 0, 3, 0, 0, 0, 20,   1,  0, 20, 0);

        // Low integer value: the -2 correction clamps at zero
        step("sat_0", 1, 0, 3, 0, 0, 1, 1,    1,  1,  2, 0);
        step("sat_1", 1, 0, 3, 0, 0, 0, 1,    1, -2,  0, 1);
        step("sat_2", 1, 0, 3, 0, 0, 0, 1,    1,  1,  2, 0);
        step("sat_3", 1, 0, 3, 0, 0, 0, 1,    1,  0,  1, 0);

        // Order change 3->2 in RUN: refill, order-2 formula, q3 ignored
        step("c2_a",  1, 0, 2, 0, 1, 1, 20,   0,  0, 20, 0);
        step("c2_b",  1, 0, 2, 0, 0, 0, 20,   0,  1, 21, 0);
        step("c2_c",  1, 0, 2, 0, 0, 0, 20,   1, -1, 19, 0);
        step("c2_d",  1, 0, 2, 0, 0, 0, 20,   1,  0, 20, 0);

        // Enable gap: registers hold, valid drops, no refill afterwards
        for (int i = 0; i < 4; i++)
            step($sformatf("gap%0d", i), 0, 0, 2, 1, 1, 1, 50,   0, 0, 20, 0);
        step("gap_end", 1, 0, 2, 0, 0, 0, 50,  1,  0, 50, 0);

        // Bypass: zero correction, refill on the order change
        step("b0_a",  1, 0, 0, 1, 1, 1, 50,   0,  0, 50, 0);
        step("b0_b",  1, 0, 0, 1, 1, 1, 50,   0,  0, 50, 0);
        step("b0_c",  1, 0, 0, 1, 1, 1, 50,   1,  0, 50, 0);

        // Top of range: 255 + 1 fits without clamping
        step("clr2",  1, 1, 1, 1, 0, 0, 255,  0,  0,  0, 0);
        step("mx_1",  1, 0, 1, 1, 0, 0, 255,  0,  0, 255, 0);
        step("mx_2",  1, 0, 1, 1, 0, 0, 255,  0,  0, 255, 0);
        step("mx_3",  1, 0, 1, 1, 0, 0, 255,  1,  1, 256, 0);

        // Asynchronous reset mid-RUN, then a full refill
        #3;
        i_rst_n = 1'b0;
        #1;
        z.tag = "arst";
        check_all(z);
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        step("ar_1",  1, 0, 1, 1, 0, 0, 255,  0,  0, 255, 0);
        step("ar_2",  1, 0, 1, 1, 0, 0, 255,  0,  0, 255, 0);
        step("ar_3",  1, 0, 1, 1, 0, 0, 255,  1,  1, 256, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
